// File: rtl/uart_pkg.sv
// UART shared definitions: frame state encoding, default baud divisor and
// parity-mode constants. Used by both the TX and RX frame engines.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // 100 MHz system clock / 9600 baud.
  localparam int unsigned DEFAULT_BAUD_DIV = 10417;

  // Parity mode select values.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity over up to 9 data bits. Narrower words are zero-extended, which
  // does not change the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..div-1 and flags the last clock of each bit.
// load_i restarts the count at load_val_i (TX loads 0, RX preloads half a
// bit so that it samples mid-bit).
module uart_bit_timer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] load_val_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 bit_done_o
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  // Not gated by load_i: the TX ready path depends on this pulse while a
  // reload is happening in the same cycle.
  assign bit_done_o = en_i && (cnt_q == (div_i - DIV_WIDTH'(1)));

  // Next count: reload wins, wrap at the end of a bit, else count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (bit_done_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter frame engine: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, 1 or 2 stop bits, runtime bit period.
// Optional feature macro: UART_TX_PARITY_EN adds parity_en/parity_odd ports
// and the PARITY state; without it frames are start + data + stop.
//
// Handshake: a word transfers on any rising edge where tx_valid && tx_ready.
// tx_ready is high in IDLE and in the last clock of the last stop bit, so a
// source that keeps tx_valid high gets back-to-back frames with no idle
// clock. tx_data is not captured on any other edge.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = DEFAULT_BAUD_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic                  stop2,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
`ifdef UART_TX_PARITY_EN
  input  logic                  parity_en,
  input  logic                  parity_odd,
`endif
  output logic                  tx_ready,
  output logic                  txd,
  output logic                  busy
);

  localparam logic [DIV_WIDTH-1:0] DEF_DIV_W = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [3:0]           LAST_BIT  = 4'(DATA_WIDTH - 1);

  uart_state_e           state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  stop2_q;
  logic [3:0]            bit_idx_q;
  logic                  stop_idx_q;
  logic                  txd_q;
  logic                  busy_q;
`ifdef UART_TX_PARITY_EN
  logic                  par_en_q;
  logic                  par_bit_q;
`endif

  logic                  bit_done;
  logic                  accept;
  logic                  last_stop;
  logic [DIV_WIDTH-1:0]  eff_div;

  // A zero divisor selects the default baud rate.
  assign eff_div   = (clk_div == '0) ? DEF_DIV_W : clk_div;
  assign last_stop = stop_idx_q || !stop2_q;
  assign tx_ready  = (state_q == IDLE) ||
                     ((state_q == STOP) && bit_done && last_stop);
  assign accept    = tx_valid && tx_ready;
  assign txd       = txd_q;
  assign busy      = busy_q;

  uart_bit_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i ('0),
    .en_i       (state_q != IDLE),
    .div_i      (div_q),
    .bit_done_o (bit_done)
  );

  // Frame FSM: accept latches the word and settings; each bit end advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      div_q      <= '0;
      stop2_q    <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else if (accept) begin
      state_q    <= START;
      shift_q    <= tx_data;
      div_q      <= eff_div;
      stop2_q    <= stop2;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      txd_q      <= 1'b0;
      busy_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= parity_en;
      par_bit_q  <= parity_bit(9'(tx_data), parity_odd);
`endif
    end else if (bit_done) begin
      case (state_q)
        START: begin
          state_q <= DATA;
          txd_q   <= shift_q[0];
        end
        DATA: begin
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_q <= PARITY;
              txd_q   <= par_bit_q;
            end else begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end
`else
            state_q <= STOP;
            txd_q   <= 1'b1;
`endif
          end else begin
            bit_idx_q <= bit_idx_q + 4'd1;
            shift_q   <= shift_q >> 1;
            txd_q     <= shift_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_q <= STOP;
          txd_q   <= 1'b1;
        end
`endif
        STOP: begin
          if (!last_stop) begin
            stop_idx_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame. Expected line behaviour is built from the frame
// rules (list of bits, each repeated for the bit period) and compared with
// {txd, busy, tx_ready} on every falling edge while expectations are queued.
// Build with +define+UART_TX_PARITY_EN to include the parity frames.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int DW   = 8;
  localparam int DIVW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DIVW-1:0] clk_div = 16'd4;
  logic            stop2 = 1'b0;
  logic            tx_valid = 1'b0;
  logic [DW-1:0]   tx_data = '0;
  logic            parity_en = 1'b0;
  logic            parity_odd = 1'b0;
  logic            tx_ready;
  logic            txd;
  logic            busy;

  always #5 clk = ~clk;

  uart_tx_frame #(
    .DATA_WIDTH  (DW),
    .DIV_WIDTH   (DIVW),
    .DEFAULT_DIV (DEFAULT_BAUD_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_div    (clk_div),
    .stop2      (stop2),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
`ifdef UART_TX_PARITY_EN
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
`endif
    .tx_ready   (tx_ready),
    .txd        (txd),
    .busy       (busy)
  );

  // ---------------- scoreboard ----------------
  logic [2:0] exp_q[$];      // {txd, busy, tx_ready} per cycle
  logic       txd_log[$];    // DUT txd on every checked cycle
  int         busy_total = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  string      cur_test = "init";

  always @(negedge clk) begin
    logic [2:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      txd_log.push_back(txd);
      if (busy === 1'b1) busy_total++;
      n_checks++;
      if ({txd, busy, tx_ready} === e) n_pass++;
      else $display("FAIL %s cycle: txd/busy/ready got %b%b%b want %b",
                    cur_test, txd, busy, tx_ready, e);
    end
  end

  task automatic check_lit(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  // ---------------- model ----------------
  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(3'b101);
  endtask

  // Line expectation for one frame; trunc>0 keeps only the first trunc cycles.
  task automatic push_frame(input logic [DW-1:0] d, input logic [DIVW-1:0] div,
                            input logic s2, input logic pe, input logic po,
                            input int trunc, output int len);
    int   per;
    int   total;
    logic bits[$];
    per = (div == 0) ? int'(DEFAULT_BAUD_DIV) : int'(div);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ po);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    total = bits.size() * per;
    len = (trunc > 0 && trunc < total) ? trunc : total;
    for (int c = 0; c < len; c++)
      exp_q.push_back({bits[c / per], 1'b1, (c == total - 1)});
  endtask

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One idle cycle with tx_valid high (accept), then the frame. A nonzero
  // trunc applies reset during frame cycle trunc-1.
  task automatic send(input logic [DW-1:0] d, input logic [DIVW-1:0] div,
                      input logic s2, input logic pe, input logic po,
                      input int trunc);
    int len;
    clk_div = div; stop2 = s2; parity_en = pe; parity_odd = po;
    tx_data = d; tx_valid = 1'b1;
    push_idle(1);
    step(1);
    tx_valid = 1'b0;
    push_frame(d, div, s2, pe, po, trunc, len);
    if (trunc == 0) begin
      step(len);
    end else begin
      step(len - 1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      push_idle(1);
      step(1);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int         base;
    int         b0;
    int         len;
    logic [9:0] a5_seq;
    a5_seq = 10'b1101001010;   // start, 1,0,1,0,0,1,0,1, stop (index = bit period)

    cur_test = "reset";
    step(1);
    push_idle(2); step(2);
    rst = 1'b0;
    push_idle(2); step(2);

    // 0xA5, 4 clocks per bit, one stop bit
    cur_test = "a5_div4";
    base = txd_log.size(); b0 = busy_total;
    send(8'hA5, 16'd4, 1'b0, 1'b0, 1'b0, 0);
    check_lit("a5_busy_len", busy_total - b0, 40);
    for (int i = 0; i < 10; i++)
      check_lit($sformatf("a5_bit%0d", i), int'(txd_log[base + 1 + 4*i + 2]), int'(a5_seq[i]));
    push_idle(3); step(3);

    // one clock per bit
    cur_test = "3c_div1";
    b0 = busy_total;
    send(8'h3C, 16'd1, 1'b0, 1'b0, 1'b0, 0);
    check_lit("3c_busy_len", busy_total - b0, 10);
    push_idle(3); step(3);

    // clk_div=0 -> default period; watch start + bit0, then abort by reset
    cur_test = "div0_default";
    base = txd_log.size(); b0 = busy_total;
    send(8'h01, 16'd0, 1'b0, 1'b0, 1'b0, 2 * 10417);
    check_lit("div0_start_last", int'(txd_log[base + 1 + 10416]), 0);
    check_lit("div0_bit0_first", int'(txd_log[base + 1 + 10417]), 1);
    check_lit("div0_busy_len", busy_total - b0, 20834);
    push_idle(2); step(2);

    // back-to-back with tx_valid held high; data changes while not ready
    cur_test = "b2b";
    base = txd_log.size(); b0 = busy_total;
    clk_div = 16'd3; stop2 = 1'b0; parity_en = 1'b0;
    tx_data = 8'h01; tx_valid = 1'b1;
    push_idle(1); step(1);
    tx_data = 8'hFF;
    push_frame(8'h01, 16'd3, 1'b0, 1'b0, 1'b0, 0, len);
    step(len);
    tx_valid = 1'b0;
    push_frame(8'hFF, 16'd3, 1'b0, 1'b0, 1'b0, 0, len);
    step(len);
    push_idle(3); step(3);
    check_lit("b2b_busy_len", busy_total - b0, 60);
    check_lit("b2b_last_stop", int'(txd_log[base + 1 + 29]), 1);
    check_lit("b2b_next_start", int'(txd_log[base + 1 + 30]), 0);

    // two stop bits; settings changed mid-frame must not matter
    cur_test = "stop2_div2";
    base = txd_log.size(); b0 = busy_total;
    clk_div = 16'd2; stop2 = 1'b1; tx_data = 8'h00; tx_valid = 1'b1;
    push_idle(1); step(1);
    tx_valid = 1'b0;
    push_frame(8'h00, 16'd2, 1'b1, 1'b0, 1'b0, 0, len);
    step(5);
    clk_div = 16'd7; stop2 = 1'b0;
    step(len - 5);
    push_idle(3); step(3);
    check_lit("stop2_busy_len", busy_total - b0, 22);
    check_lit("stop2_last_data", int'(txd_log[base + 1 + 17]), 0);
    check_lit("stop2_first_stop", int'(txd_log[base + 1 + 18]), 1);
    check_lit("stop2_final_stop", int'(txd_log[base + 1 + 21]), 1);

`ifdef UART_TX_PARITY_EN
    cur_test = "par_even";
    base = txd_log.size(); b0 = busy_total;
    send(8'h07, 16'd2, 1'b0, 1'b1, PAR_EVEN, 0);
    check_lit("par_even_bit", int'(txd_log[base + 1 + 19]), 1);
    check_lit("par_even_len", busy_total - b0, 22);
    push_idle(2); step(2);

    cur_test = "par_odd";
    base = txd_log.size();
    send(8'h07, 16'd2, 1'b0, 1'b1, PAR_ODD, 0);
    check_lit("par_odd_bit", int'(txd_log[base + 1 + 19]), 0);
    push_idle(2); step(2);

    cur_test = "par_off";
    b0 = busy_total;
    send(8'h07, 16'd2, 1'b0, 1'b0, PAR_ODD, 0);
    check_lit("par_off_len", busy_total - b0, 20);
    push_idle(2); step(2);
`endif

    // reset during data bit 3, then a clean frame
    cur_test = "abort";
    send(8'hA5, 16'd4, 1'b0, 1'b0, 1'b0, 18);
    push_idle(2); step(2);
    cur_test = "after_abort";
    base = txd_log.size(); b0 = busy_total;
    send(8'hA5, 16'd4, 1'b0, 1'b0, 1'b0, 0);
    check_lit("after_abort_len", busy_total - b0, 40);
    check_lit("after_abort_bit3", int'(txd_log[base + 1 + 4*4 + 2]), int'(a5_seq[4]));
    push_idle(3); step(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
